// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: definitions shared by the data-memory arbiter.
//   - Default address and data widths for the memory port.
//   - Requester identifiers (processor data port and loader/debug port).
//   - Idle encoding of the active-low memory control pins.
//   - Issue-stage bookkeeping record.
// Used by dmem_arbiter and dmem_arb_pick. Optional feature macro: DMEM_ARB_RR_EN.
package dmem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 32;

  // Requester identifiers; also the encoding of the round-robin pointer.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  // Memory pins when no access is in progress.
  localparam logic CEN_IDLE = 1'b1;
  localparam logic WEN_IDLE = 1'b1;
  localparam logic OEN_IDLE = 1'b1;

  // What stage 1 remembers about the access it is driving onto the pins.
  typedef struct packed {
    logic valid;
    logic owner;
    logic is_read;
  } issue_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational two-way picker for the data-memory arbiter.
// Ports:
//   req0, req1 : access requests from requester 0 (CPU) and 1 (loader)
//   ptr        : preferred requester on conflict (round-robin build only)
//   gnt0, gnt1 : grants; never asserted without the matching request, never both
// Build option: DMEM_ARB_RR_EN defined selects round-robin on conflict,
// otherwise requester 0 always wins and ptr is ignored.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef DMEM_ARB_RR_EN
    if (req0 && req1) begin
      gnt0 = (ptr == REQ_CPU);
      gnt1 = (ptr == REQ_LDR);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
`else
    gnt0 = req0;
    gnt1 = req1 & ~req0;
`endif
  end

`ifndef DMEM_ARB_RR_EN
  // Fixed priority has no preferred-requester state.
  logic unused_ptr;
  assign unused_ptr = ptr;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and sequencer for the single-port data memory.
// Requester 0 is the processor data port, requester 1 the loader/debug port.
// Every memory pin is registered; read data returns two cycles after acceptance,
// tagged to the issuing requester through rvalid0/rvalid1.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*    : requester side, held stable until granted
//   gnt0, gnt1               : combinational grants (accept = req & gnt)
//   rvalid0, rvalid1, rdata  : read return, rdata is 0 when neither rvalid is high
//   CEN, WEN, OEN, A, Data2Mem : registered memory pins (active-low controls)
//   ReadDataMem              : memory read data, valid the cycle after the read CEN
// Build option: DMEM_ARB_RR_EN selects round-robin conflict resolution, otherwise
// fixed priority to requester 0 and no pointer register.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data2Mem,
  input  logic [DATA_W-1:0] ReadDataMem
);

  logic ptr;
  logic accept;
  logic sel;
  logic sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic ret_rd;

  issue_t            s1_d, s1_q;
  logic              cen_d, cen_q;
  logic              wen_d, wen_q;
  logic              oen_d, oen_q;
  logic [ADDR_W-1:0] a_d, a_q;
  logic [DATA_W-1:0] data2mem_d, data2mem_q;
  logic              rvalid0_d, rvalid0_q;
  logic              rvalid1_d, rvalid1_q;

  dmem_arb_pick u_pick (
    .req0 (req0),
    .req1 (req1),
    .ptr  (ptr),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

`ifdef DMEM_ARB_RR_EN
  logic ptr_q;

  // After any grant the other requester becomes preferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_CPU;
    end else if (accept) begin
      ptr_q <= ~sel;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = REQ_CPU;
`endif

  always_comb begin
    // Grants are already qualified by req, so either grant means acceptance.
    accept    = gnt0 | gnt1;
    sel       = gnt1 ? REQ_LDR : REQ_CPU;
    sel_we    = (sel == REQ_LDR) ? we1    : we0;
    sel_addr  = (sel == REQ_LDR) ? addr1  : addr0;
    sel_wdata = (sel == REQ_LDR) ? wdata1 : wdata0;

    // Stage 1: drive the memory pins for the accepted access.
    s1_d.valid   = accept;
    s1_d.owner   = sel;
    s1_d.is_read = ~sel_we;
    cen_d        = accept ? 1'b0 : CEN_IDLE;
    wen_d        = accept ? ~sel_we : WEN_IDLE;
    a_d          = accept ? sel_addr : a_q;
    // Write data only changes on writes so the data bus stays quiet on reads.
    data2mem_d   = (accept && sel_we) ? sel_wdata : data2mem_q;

    // Stage 2: the memory presents read data the cycle after its CEN cycle.
    ret_rd    = s1_q.valid & s1_q.is_read;
    oen_d     = ret_rd ? 1'b0 : OEN_IDLE;
    rvalid0_d = ret_rd & (s1_q.owner == REQ_CPU);
    rvalid1_d = ret_rd & (s1_q.owner == REQ_LDR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      cen_q      <= CEN_IDLE;
      wen_q      <= WEN_IDLE;
      oen_q      <= OEN_IDLE;
      a_q        <= '0;
      data2mem_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      oen_q      <= oen_d;
      a_q        <= a_d;
      data2mem_q <= data2mem_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign CEN      = cen_q;
  assign WEN      = wen_q;
  assign OEN      = oen_q;
  assign A        = a_q;
  assign Data2Mem = data2mem_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  // Memory data passes straight through during the return cycle only.
  assign rdata    = (rvalid0_q | rvalid1_q) ? ReadDataMem : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic from
// both requesters, checked by a scoreboard against a word-level memory model.
module tb_dmem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, CEN, WEN, OEN;
  logic [DW-1:0] rdata, Data2Mem, ReadDataMem;
  logic [AW-1:0] A;

  int errors = 0;
  int checks = 0;

  // Memory attached to the pins, and the bench's own view of its contents.
  logic [DW-1:0] sram    [128];
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] rd_q;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
  } ret_t;
  ret_t exp_q[$];
  ret_t mon_r;

  logic          exp_cen = 1'b1, exp_wen = 1'b1;
  logic [AW-1:0] exp_a = '0;
  logic [DW-1:0] exp_d = '0;
  logic          ref_ptr = 1'b0;
  logic          pref0, e0, e1, w, w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  dmem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .we0         (we0),
    .addr0       (addr0),
    .wdata0      (wdata0),
    .req1        (req1),
    .we1         (we1),
    .addr1       (addr1),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rvalid0     (rvalid0),
    .rvalid1     (rvalid1),
    .rdata       (rdata),
    .CEN         (CEN),
    .WEN         (WEN),
    .OEN         (OEN),
    .A           (A),
    .Data2Mem    (Data2Mem),
    .ReadDataMem (ReadDataMem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!CEN && !WEN) sram[A] <= Data2Mem;
    if (!CEN && WEN)  rd_q    <= sram[A];
  end
  assign ReadDataMem = rd_q;

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    return 32'hA5A5_0000 ^ (i * 32'h0101_0101);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cen"}, CEN, 1);
    chk({tag, "_wen"}, WEN, 1);
    chk({tag, "_oen"}, OEN, 1);
    chk({tag, "_a"}, A, 0);
    chk({tag, "_data2mem"}, Data2Mem, 0);
    chk({tag, "_rvalid"}, {rvalid1, rvalid0}, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: arbitration rule, pin expectations and in-order read results.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cen = 1'b1;
      exp_wen = 1'b1;
      exp_a   = '0;
      exp_d   = '0;
      ref_ptr = 1'b0;
    end else begin
      chk("pin_cen", CEN, exp_cen);
      chk("pin_wen", WEN, exp_wen);
      chk("pin_a", A, exp_a);
      chk("pin_data2mem", Data2Mem, exp_d);
`ifdef DMEM_ARB_RR_EN
      pref0 = (ref_ptr == 1'b0);
`else
      pref0 = 1'b1;
`endif
      e0 = req0 && (!req1 || pref0);
      e1 = req1 && !e0;
      chk("gnt0", gnt0, e0);
      chk("gnt1", gnt1, e1);
      if (e0 || e1) begin
        w      = e1;
        w_we   = w ? we1 : we0;
        w_addr = w ? addr1 : addr0;
        w_data = w ? wdata1 : wdata0;
        exp_cen = 1'b0;
        exp_wen = !w_we;
        exp_a   = w_addr;
        if (w_we) begin
          exp_d = w_data;
          ref_mem[w_addr] = w_data;
        end else begin
          exp_q.push_back('{owner: w, data: ref_mem[w_addr]});
        end
        ref_ptr = !w;
      end else begin
        exp_cen = 1'b1;
        exp_wen = 1'b1;
      end
    end
  end

  // Monitor: pops one expected result whenever the DUT returns read data.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rvalid_exclusive", rvalid0 & rvalid1, 0);
      chk("oen", OEN, !(rvalid0 | rvalid1));
      if (rvalid0 || rvalid1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", {rvalid1, rvalid0}, 0);
        end else begin
          mon_r = exp_q.pop_front();
          chk("rvalid_owner", rvalid1, mon_r.owner);
          chk("rdata", rdata, mon_r.data);
        end
      end else begin
        chk("rdata_idle", rdata, 0);
      end
    end
  end

  initial begin
    logic p0, p1;
    for (int i = 0; i < 128; i++) begin
      sram[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end

    // Power-on reset and idle.
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_gnt", {gnt1, gnt0}, 0);
    end

    // Both requesters reading for four cycles, pointer fresh from reset.
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'h02;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      chk("conflict_gnt", {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      chk("conflict_gnt", {gnt1, gnt0}, 2'b01);
`endif
      step();
    end
    req0 = 1'b0; req1 = 1'b0;

    // Write then read the same word from requester 0.
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h05; wdata0 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_gnt", gnt0, 1);
    step();
    we0 = 1'b0;
    @(negedge clk);
    chk("wr_cen", CEN, 0);
    chk("wr_wen", WEN, 0);
    chk("wr_a", A, 7'h05);
    chk("wr_data2mem", Data2Mem, 32'hDEAD_BEEF);
    chk("rd_gnt", gnt0, 1);
    step();
    req0 = 1'b0;
    @(negedge clk);
    chk("rd_cen", CEN, 0);
    chk("rd_wen", WEN, 1);
    chk("rd_data2mem_hold", Data2Mem, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rd_rvalid0", {rvalid1, rvalid0}, 2'b01);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);

    // Read 0 then read 1 back-to-back.
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h03;
    step();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 7'h04;
    step();
    req1 = 1'b0;
    @(negedge clk);
    chk("alt_first", {rvalid1, rvalid0}, 2'b01);
    chk("alt_first_data", rdata, init_word(3));
    @(negedge clk);
    chk("alt_second", {rvalid1, rvalid0}, 2'b10);
    chk("alt_second_data", rdata, init_word(4));

    // Reset during the CEN cycle of a read discards it.
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h03;
    step();
    req0 = 1'b0;
    chk("rst_read_cen", CEN, 0);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rvalid", {rvalid1, rvalid0}, 0);
    end

    // Requester 1 loses a conflict and withdraws its write.
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h06;
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h7F; wdata1 = 32'h1234_5678;
    @(negedge clk);
    chk("drop_gnt", {gnt1, gnt0}, 2'b01);
    step();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("drop_gnt1", gnt1, 0);
    chk("drop_a", A, 7'h06);
    @(negedge clk);
    chk("drop_idle_cen", CEN, 1);
    chk("drop_mem", sram[127], init_word(127));

    // Random traffic from both requesters.
    p0 = 1'b0;
    p1 = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (req0 && gnt0) p0 = 1'b0;
      if (req1 && gnt1) p1 = 1'b0;
      step();
      if (!p0) begin
        req0 = ($urandom_range(0, 3) != 0);
        we0 = 1'($urandom_range(0, 1));
        addr0 = 7'($urandom_range(0, 15));
        wdata0 = $urandom;
        p0 = req0;
      end else if ($urandom_range(0, 15) == 0) begin
        req0 = 1'b0;
        p0 = 1'b0;
      end
      if (!p1) begin
        req1 = ($urandom_range(0, 3) != 0);
        we1 = 1'($urandom_range(0, 1));
        addr1 = 7'($urandom_range(0, 15));
        wdata1 = $urandom;
        p1 = req1;
      end else if ($urandom_range(0, 15) == 0) begin
        req1 = 1'b0;
        p1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (6) @(negedge clk);
    chk("drain_outstanding", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
